sequence_stats: RTL

- Downstream consumer of the arithmetic sequence generator. It accumulates statistics over one generated sequence: sample count, signed sum, minimum and maximum.
- When the generator's done level rises, the block presents the results to a report consumer through a valid/ready handshake.
- After the report is accepted, it re-arms for the next sequence.

---
 rtl/sequence_stats.sv | 124 ++++++++++++
 1 files changed

// File: rtl/sequence_stats.sv
// Per-sequence statistics (count, saturating signed sum, min, max) over samples
// from the arithmetic sequence generator, reported through a valid/ready handshake.
module sequence_stats #(
  parameter int DATA_W = 32,
  parameter int SUM_W  = 48,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              seq_valid,
  input  logic [DATA_W-1:0] seq_value,
  input  logic              seq_done,
  output logic              stats_valid,
  input  logic              stats_ready,
  output logic [CNT_W-1:0]  stats_count,
  output logic [SUM_W-1:0]  stats_sum,
  output logic [DATA_W-1:0] stats_min,
  output logic [DATA_W-1:0] stats_max,
  output logic              stats_empty,
  output logic              sum_ovf,
  output logic              cnt_ovf,
  output logic              overrun
);

  typedef enum logic [1:0] {IDLE, COLLECT, REPORT} state_t;

  localparam logic [SUM_W-1:0] SUM_MAX = {1'b0, {(SUM_W-1){1'b1}}};
  localparam logic [SUM_W-1:0] SUM_MIN = {1'b1, {(SUM_W-1){1'b0}}};

  state_t                  state;
  logic                    done_q;
  logic                    done_rise;
  logic                    cnt_full;
  logic                    sum_clip;
  logic                    new_min;
  logic                    new_max;
  logic signed [SUM_W:0]   samp_ext;
  logic signed [SUM_W:0]   sum_wide;
  logic        [SUM_W-1:0] sum_next;

  // One guard bit above SUM_W exposes signed overflow as a mismatch of the top two bits.
  always_comb begin
    done_rise = seq_done & ~done_q;
    cnt_full  = (stats_count == '1);
    samp_ext  = (SUM_W+1)'($signed(seq_value));
    sum_wide  = $signed({stats_sum[SUM_W-1], stats_sum}) + samp_ext;
    sum_clip  = sum_wide[SUM_W] ^ sum_wide[SUM_W-1];
    sum_next  = sum_wide[SUM_W-1:0];
    if (sum_clip) begin
      sum_next = sum_wide[SUM_W] ? SUM_MIN : SUM_MAX;
    end
    new_min = $signed(seq_value) < $signed(stats_min);
    new_max = $signed(seq_value) > $signed(stats_max);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      done_q      <= 1'b0;
      stats_valid <= 1'b0;
      stats_count <= '0;
      stats_sum   <= '0;
      stats_min   <= '0;
      stats_max   <= '0;
      stats_empty <= 1'b0;
      sum_ovf     <= 1'b0;
      cnt_ovf     <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      done_q  <= seq_done;
      overrun <= ~clear & (state == REPORT) & seq_valid;
      if (clear || (state == REPORT && stats_ready)) begin
        state       <= IDLE;
        stats_valid <= 1'b0;
        stats_count <= '0;
        stats_sum   <= '0;
        stats_min   <= '0;
        stats_max   <= '0;
        stats_empty <= 1'b0;
        sum_ovf     <= 1'b0;
        cnt_ovf     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            // Stats are always zero in IDLE, so the first sample loads directly.
            if (seq_valid) begin
              stats_count <= CNT_W'(1);
              stats_sum   <= samp_ext[SUM_W-1:0];
              stats_min   <= seq_value;
              stats_max   <= seq_value;
            end
            if (done_rise) begin
              state       <= REPORT;
              stats_valid <= 1'b1;
              stats_empty <= ~seq_valid;
            end else if (seq_valid) begin
              state <= COLLECT;
            end
          end
          COLLECT: begin
            if (seq_valid) begin
              if (cnt_full) begin
                cnt_ovf <= 1'b1;
              end else begin
                stats_count <= stats_count + 1'b1;
                stats_sum   <= sum_next;
                if (sum_clip) sum_ovf <= 1'b1;
                if (new_min) stats_min <= seq_value;
                if (new_max) stats_max <= seq_value;
              end
            end
            if (done_rise) begin
              state       <= REPORT;
              stats_valid <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
